cic_decimator: RTL and testbench
================================

// Module: cic_decimator
// PURPOSE
// - Downstream stage of the 2nd-order IIR notch. Consumes the notch output samples, 6 MS/s on the 18 MHz clock.
// - Decimates by a runtime-selectable power of two R using an N-stage CIC: integrators, then down-sample, then combs.
// - Normalises the R^N gain exactly and emits Q1.15 samples with a valid strobe.
// PARAMETERS
// DATA_WIDTH   16  input/output sample width, signed Q1.15
// N_STAGES     3   number of integrator and comb stages (1..4)
// MAX_LOG2R    4   log2 of the largest decimation factor, so R max = 16
// - localparam ACC_WIDTH = DATA_WIDTH + N_STAGES*MAX_LOG2R (28 with defaults)
// PORTS
// clk        in   1           system clock, 18 MHz; the only clock
// rst_n      in   1           synchronous active-low reset
// dec_sel    in   3           decimation select: 0->R=1, 1->2, 2->4, 3->8, 4->16, 5..7->16
// valid_in   in   1           x_in holds a new sample this cycle
// x_in       in   DATA_WIDTH  signed input sample (notch output)
// x_out      out  DATA_WIDTH  signed decimated output sample
// valid_out  out  1           one-cycle pulse when x_out updates
// BEHAVIOUR
// - Reset: one clock, synchronous, active-low (rst_n low at a clk edge).
//   - Clears x_out, valid_out, all integrator and comb state, the phase counter and the registered dec_sel.
// - Sample acceptance: a sample is taken only on edges where valid_in=1. Gaps of any length are allowed.
//   - The phase counter counts accepted samples 0..R-1 and wraps to 0.
// - Integrators:
//   - On each accepted sample, all N integrators update in the same edge as a combinational chain: I1+=x_in (sign-extended), Ik+=I(k-1).
//   - Arithmetic is ACC_WIDTH two's-complement modulo. Wrap-around is intentional and must not saturate.
// - Decimation: when an accepted sample has phase R-1, the updated IN value is latched into the comb pipeline with a strobe.
// - Combs:
//   - N registered stages, one clock each, differential delay M=1: Ck = in - in_prev.
//   - The in_prev registers update only on a strobe.
//   - The pipeline is fully pipelined, so back-to-back strobes are allowed (needed for R=1 with valid_in held high).
// - Normalise:
//   - s = N_STAGES*log2(R).
//   - y = (comb_out + 2^(s-1)) >>> s (round half up); for s=0 there is no rounding.
//   - Saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
// - Latency: valid_out pulses exactly N_STAGES+2 clocks after the edge that accepted the phase R-1 sample.
//   - x_out holds its value between pulses.
// - Config change: dec_sel is registered every cycle.
//   - If it differs from the registered value, the next edge clears the integrators, combs, phase counter and in-flight strobes.
//   - x_out keeps its last value. Partial groups are discarded and no valid_out is produced for them.
//   - The sample accepted on that clearing edge is dropped.
// - Simultaneous events:
//   - rst_n low wins over everything.
//   - A dec_sel change wins over a valid_in in the same cycle.
// - Reset mid-stream: everything is flushed and no pending valid_out appears after reset releases.
// - After a clear, the first N-1 decimated outputs are the true zero-history transient and are still flagged valid.
// TESTING
// - Reset: hold rst_n low 2 cycles mid-stream.
//   - x_out=0 and valid_out=0 from the next edge.
//   - No valid_out for 20 cycles after release with valid_in=0.
// - DC, R=4 (dec_sel=2): x_in=16'h4000 with valid_in every 3rd cycle.
//   - One valid_out per 12 cycles.
//   - x_out=16'h4000 exactly from the 3rd output onward.
// - Bypass, R=1 (dec_sel=0): valid_in=1 every cycle with a ramp 0,1,2,...
//   - x_out equals x_in delayed 5 cycles.
//   - valid_out is held high continuously.
// - Extremes, R=16: DC 16'h7FFF gives 16'h7FFF once settled; DC 16'h8000 gives 16'h8000. No wrap artefacts.
// - Alternating input, R=2: x_in alternating +16'h2000/-16'h2000 (Nyquist) gives x_out=0 once settled.
// - Config change mid-group: R=8, send 5 samples, then switch to dec_sel=1.
//   - No output is produced for the partial group.
//   - The first valid_out comes 5 cycles after the 2nd sample accepted post-clear.

Source files
------------

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with runtime power-of-two rate, exact R^N gain normalisation
// (round half up, saturate) and a fixed N_STAGES+2 cycle accept-to-output latency.
module cic_decimator #(
  parameter int DATA_WIDTH = 16,
  parameter int N_STAGES   = 3,
  parameter int MAX_LOG2R  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   dec_sel,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         valid_out
);

  localparam int ACC_WIDTH = DATA_WIDTH + N_STAGES*MAX_LOG2R;
  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_LO = ~SAT_HI;

  logic [2:0]                  dec_q;
  logic [MAX_LOG2R-1:0]        phase_q;
  logic signed [ACC_WIDTH-1:0] integ_q    [N_STAGES];
  logic signed [ACC_WIDTH-1:0] integ_d    [N_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_q     [N_STAGES+1];
  logic signed [ACC_WIDTH-1:0] comb_prev_q[N_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_d     [N_STAGES];
  logic [N_STAGES:0]           stb_q;
  logic signed [ACC_WIDTH:0]   rnd_q, rnd_d, rnd_sum, rnd_add;
  logic                        rnd_stb_q;
  logic signed [DATA_WIDTH-1:0] x_out_q, sat_d;
  logic                        valid_q;

  logic                        cfg_chg;
  logic                        phase_last;
  int unsigned                 log2r;
  int unsigned                 shamt;

  always_comb begin
    cfg_chg    = (dec_sel != dec_q);
    log2r      = (int'(dec_q) > MAX_LOG2R) ? MAX_LOG2R : int'(dec_q);
    shamt      = N_STAGES * log2r;
    phase_last = (32'(phase_q) == ((32'd1 << log2r) - 32'd1));

    // Integrator cascade settles combinationally so the decimated tap sees this sample.
    integ_d[0] = integ_q[0] + {{(ACC_WIDTH-DATA_WIDTH){x_in[DATA_WIDTH-1]}}, x_in};
    for (int unsigned k = 1; k < N_STAGES; k++) begin
      integ_d[k] = integ_q[k] + integ_d[k-1];
    end

    for (int unsigned k = 0; k < N_STAGES; k++) begin
      comb_d[k] = comb_q[k] - comb_prev_q[k];
    end

    rnd_add = (shamt == 0) ? '0 : ((ACC_WIDTH+1)'(1) <<< (shamt - 1));
    rnd_sum = {comb_q[N_STAGES][ACC_WIDTH-1], comb_q[N_STAGES]} + rnd_add;
    rnd_d   = rnd_sum >>> shamt;

    if (rnd_q > SAT_HI)      sat_d = SAT_HI[DATA_WIDTH-1:0];
    else if (rnd_q < SAT_LO) sat_d = SAT_LO[DATA_WIDTH-1:0];
    else                     sat_d = rnd_q[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q     <= '0;
      phase_q   <= '0;
      stb_q     <= '0;
      rnd_q     <= '0;
      rnd_stb_q <= 1'b0;
      x_out_q   <= '0;
      valid_q   <= 1'b0;
      for (int unsigned k = 0; k < N_STAGES; k++) begin
        integ_q[k]     <= '0;
        comb_prev_q[k] <= '0;
      end
      for (int unsigned k = 0; k <= N_STAGES; k++) comb_q[k] <= '0;
    end else begin
      dec_q <= dec_sel;
      if (cfg_chg) begin
        // Rate change flushes all filter history; x_out deliberately keeps its last value.
        phase_q   <= '0;
        stb_q     <= '0;
        rnd_stb_q <= 1'b0;
        valid_q   <= 1'b0;
        for (int unsigned k = 0; k < N_STAGES; k++) begin
          integ_q[k]     <= '0;
          comb_prev_q[k] <= '0;
        end
        for (int unsigned k = 0; k <= N_STAGES; k++) comb_q[k] <= '0;
      end else begin
        if (valid_in) begin
          integ_q <= integ_d;
          phase_q <= phase_last ? '0 : phase_q + MAX_LOG2R'(1);
        end
        stb_q[0] <= valid_in && phase_last;
        if (valid_in && phase_last) comb_q[0] <= integ_d[N_STAGES-1];
        for (int unsigned k = 0; k < N_STAGES; k++) begin
          stb_q[k+1] <= stb_q[k];
          if (stb_q[k]) begin
            comb_q[k+1]    <= comb_d[k];
            comb_prev_q[k] <= comb_q[k];
          end
        end
        rnd_stb_q <= stb_q[N_STAGES];
        if (stb_q[N_STAGES]) rnd_q <= rnd_d;
        valid_q <= rnd_stb_q;
        if (rnd_stb_q) x_out_q <= sat_d;
      end
    end
  end

  assign x_out     = x_out_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator (defaults: 16-bit, N=3, R up to 16).
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  dec_sel;
  logic        valid_in;
  logic [15:0] x_in;
  logic [15:0] x_out;
  logic        valid_out;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  int a_edge;
  logic [15:0] outs[$];
  int          ocyc[$];

  cic_decimator #(.DATA_WIDTH(16), .N_STAGES(3), .MAX_LOG2R(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dec_sel  (dec_sel),
    .valid_in (valid_in),
    .x_in     (x_in),
    .x_out    (x_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid_out) begin
      outs.push_back(x_out);
      ocyc.push_back(cyc);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; dec_sel = 3'd0; valid_in = 1'b0; x_in = '0;
    tick(); tick();
    chk("rst_xout", 32'(x_out), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    rst_n = 1'b1;
    tick();

    // DC 0x4000, R=4, one sample every 3rd cycle; h = 1,3,6,10,12,12,10,6,3,1 (sum 64)
    dec_sel = 3'd2; tick();
    outs.delete(); ocyc.delete();
    a_edge = 0;
    for (int g = 0; g < 22; g++) begin
      valid_in = 1'b1; x_in = 16'h4000; tick();
      if (g == 0) a_edge = cyc;
      valid_in = 1'b0; tick(); tick();
    end
    chk("dc_count", 32'(outs.size()), 32'd5);
    if (outs.size() >= 5) begin
      chk("dc_latency", 32'(ocyc[0] - a_edge), 32'd14);
      for (int i = 1; i < 5; i++) chk("dc_period", 32'(ocyc[i] - ocyc[i-1]), 32'd12);
      chk("dc_out0", 32'(outs[0]), 32'd5120);
      chk("dc_out1", 32'(outs[1]), 32'd15360);
      for (int i = 2; i < 5; i++) chk("dc_settled", 32'(outs[i]), 32'h4000);
    end

    // Complete a group, then reset while its output is still in flight
    for (int g = 0; g < 2; g++) begin
      valid_in = 1'b1; x_in = 16'h4000; tick();
      valid_in = 1'b0; tick(); tick();
    end
    outs.delete(); ocyc.delete();
    rst_n = 1'b0; valid_in = 1'b1;
    tick();
    chk("midrst_xout", 32'(x_out), 32'h0);
    chk("midrst_valid", 32'(valid_out), 32'h0);
    tick();
    rst_n = 1'b1; valid_in = 1'b0;
    repeat (20) tick();
    chk("midrst_quiet", 32'(outs.size()), 32'd0);

    // Bypass R=1: identity with 5-cycle latency
    dec_sel = 3'd0; valid_in = 1'b0; tick();
    outs.delete(); ocyc.delete();
    for (int k = 0; k < 20; k++) begin
      valid_in = 1'b1; x_in = 16'(k); tick();
      if (k == 4) chk("byp_lat", 32'(valid_out), 32'h0);
      if (k >= 5) begin
        chk("byp_valid", 32'(valid_out), 32'h1);
        chk("byp_data", 32'(x_out), 32'(k - 5));
      end
    end

    // Extremes, R=16
    dec_sel = 3'd4; valid_in = 1'b0; tick();
    outs.delete(); ocyc.delete();
    valid_in = 1'b1; x_in = 16'h7FFF;
    repeat (112) tick();
    x_in = 16'h8000;
    repeat (96) tick();
    valid_in = 1'b0;
    repeat (8) tick();
    chk("ext_count", 32'(outs.size()), 32'd13);
    if (outs.size() >= 13) begin
      for (int i = 2; i < 7; i++)  chk("ext_pos", 32'(outs[i]), 32'h7FFF);
      for (int i = 9; i < 13; i++) chk("ext_neg", 32'(outs[i]), 32'h8000);
    end

    // Nyquist alternation, R=2: h = 1,3,3,1 so first output is 2*0x2000/8
    dec_sel = 3'd1; valid_in = 1'b0; tick();
    outs.delete(); ocyc.delete();
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1; x_in = (i % 2 == 0) ? 16'h2000 : 16'hE000; tick();
    end
    valid_in = 1'b0;
    repeat (8) tick();
    chk("alt_count", 32'(outs.size()), 32'd8);
    if (outs.size() >= 8) begin
      chk("alt_out0", 32'(outs[0]), 32'h0800);
      for (int i = 1; i < 8; i++) chk("alt_zero", 32'(outs[i]), 32'h0);
    end

    // Config change mid-group: R=8 partial, then R=2 with sample on clearing edge dropped
    dec_sel = 3'd3; valid_in = 1'b0; tick();
    outs.delete(); ocyc.delete();
    valid_in = 1'b1; x_in = 16'd1000;
    repeat (5) tick();
    chk("cfg_partial", 32'(outs.size()), 32'd0);
    dec_sel = 3'd1;
    tick();
    chk("cfg_clear_edge", 32'(valid_out), 32'h0);
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t < 7) chk("cfg_quiet", 32'(valid_out), 32'h0);
      else begin
        chk("cfg_valid", 32'(valid_out), 32'h1);
        chk("cfg_data", 32'(x_out), 32'd500);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
